// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
// Encoding 2'd3 is unused and steers the FSM back to idle.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_d    = w_axb ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, D = A - B - Bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flip-flop; start/busy/done handshake.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; D/Bout hold the last result
//   ST_SHIFT | one operand bit processed per edge, W edges in total
//   ST_DONE  | one-cycle result-valid pulse; start here is accepted back-to-back
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_d,
    output logic         o_bout,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a_sr;
    logic [W-1:0]       r_b_sr;
    logic [W-1:0]       r_res_sr;
    logic [W-1:0]       r_d;
    logic               r_bout;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_bout;
    logic [W-1:0]       w_res_next;

    full_subtractor u_fs (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_br),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_accept   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_res_next = {w_d, r_res_sr[W-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = i_start ? ST_SHIFT : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // D and Bout are only written on the final shift edge, so they survive a new accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= i_a;
            r_b_sr <= i_b;
            r_br   <= i_bin;
            r_cnt  <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_br     <= w_bout;
            r_res_sr <= w_res_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_d    <= w_res_next;
                r_bout <= w_bout;
            end
        end
    end

    assign o_d    = r_d;
    assign o_bout = r_bout;
    assign o_busy = (r_state == ST_SHIFT);
    assign o_done = (r_state == ST_DONE);

endmodule
